exc_arbiter: RTL
================

Name: exc_arbiter

Overview:
Parametrised exception/interrupt front end for the core control path. It generalises the FIQ/IRQ synchroniser and abort one-shot logic to NCH maskable interrupt channels with configurable synchroniser depth. It adds prioritised arbitration, a held request/acknowledge handshake with the pipeline and a post-acknowledge hold-off window. It sits between the external interrupt/abort pins and the fetch/interlock logic, and drives the exception request and code into decode.

Parameters:
NCH, 2, number of active-low interrupt channels; channel 0 has the highest interrupt priority (FIQ-like).
SYNC_DEPTH, 2, synchroniser flops per channel used when ISYNC=0; legal range 1..4.
HOLDOFF, 3, cycles after exc_ack during which no new request is raised; 0 disables the hold-off.
CW, 3, exc_code width; must satisfy 2^CW >= NCH+2.

Ports:
nGCLK  in  1  core clock; all state updates on its rising edge.
RESET  in  1  asynchronous, active-high reset.
nWAIT  in  1  low freezes all internal state and outputs.
ISYNC  in  1  1 = inputs already synchronous, so the synchroniser chain is bypassed.
nINT  in  NCH  active-low interrupt lines, level sensitive.
int_disable  in  NCH  per-channel mask (CPSR F/I style); 1 = masked.
DABORT  in  1  data abort, level; only a rising edge counts.
IABORT  in  1  instruction abort, level; only a rising edge counts.
exc_ack  in  1  pipeline has taken the current request.
exc_req  out  1  exception request to decode, held until acknowledged.
exc_code  out  CW  0 = data abort, 1 = instruction abort, 2+i = interrupt channel i.
s_nINT  out  NCH  synchronised, masked interrupt levels (active low).
busy  out  1  high in PEND or HOLD state.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: exc_req=0, exc_code=0, s_nINT=all 1, busy=0. Synchroniser flops reset to 1; abort edge and sticky-pending flops reset to 0; state returns to IDLE; hold-off counter is 0.
- Masking is applied before synchronisation: the input to the chain is nINT|int_disable.
- Synchroniser latency with ISYNC=1: s_nINT reflects the input after 1 edge.
- Synchroniser latency with ISYNC=0: s_nINT reflects the input after SYNC_DEPTH edges.
- Switching ISYNC mid-run takes effect at the next edge. The chain keeps shifting in both modes.
- Abort one-shot: a rising edge of DABORT or IABORT, compared with its previous sampled value, sets sticky flag dab_pend or iab_pend. A level held high sets the flag only once.
- The sticky flags clear only when the pipeline acknowledges that abort.
- Priority order: dab_pend > iab_pend > channel 0 > ... > channel NCH-1.
- FSM IDLE: if any candidate is present, then at the next edge exc_req=1, exc_code=winner and state=PEND.
- FSM PEND: exc_req and exc_code are held stable. A higher-priority event arriving meanwhile does NOT change exc_code. Abort events are still captured into the sticky flags.
- In PEND, exc_ack=1 at an edge does three things: exc_req goes to 0 the same edge; the served abort flag clears; the next state is HOLD with counter=HOLDOFF, or IDLE if HOLDOFF=0.
- FSM HOLD: the counter decrements each edge and the state goes to IDLE when it reaches 1. exc_req stays 0 throughout.
- Interrupts are level sensitive and are not latched. A channel that deasserts while in PEND is still reported; software handles spurious interrupts.
- exc_ack is ignored in IDLE and HOLD.
- Request latency: interrupt with ISYNC=1 is 2 edges from input to exc_req. Interrupt with ISYNC=0 is SYNC_DEPTH+1 edges. Abort edge to exc_req is 2 edges.
- nWAIT=0: every register (chain, edge flops, flags, FSM, counter) holds its value, and exc_ack is ignored.
- Same-edge abort rise and exc_ack for the same abort type: the ack clears the old flag and the new edge sets it again, so set wins.
- RESET asserted in any state returns all state to reset values immediately, without waiting for a clock edge.
- With RESET deasserted, the first request can appear no earlier than 2 edges later.

Test Plan:
- Reset/idle: assert RESET with nINT=0 -> exc_req=0, s_nINT=2'b11. Release RESET with inputs idle -> exc_req stays 0 for 10 cycles.
- Sync latency: ISYNC=0, SYNC_DEPTH=2, drop nINT[1] at cycle 0 -> s_nINT[1]=0 after edge 2, exc_req=1 with exc_code=3 after edge 3. Repeat with ISYNC=1 -> exc_req after edge 2.
- Priority and stability: nINT=2'b00 and DABORT rising on the same cycle -> exc_code=0. Then raise IABORT while in PEND -> exc_code stays 0. exc_ack -> 3 HOLD cycles with exc_req=0, then exc_code=1 is requested.
- One-shot: hold DABORT high for 20 cycles and ack the request -> exactly one request with code 0. DABORT falls and rises again -> a second request.
- Masking and wait: int_disable[0]=1 with nINT[0]=0 -> no request. Hold nWAIT=0 while exc_req=1 and exc_ack=1 -> exc_req stays 1 and the FSM does not advance.
- Reset mid-operation: assert RESET in PEND and in HOLD (counter=2) -> exc_req=0 and busy=0 asynchronously. Sticky flags are cleared, so no replay of a pre-reset abort occurs after release.

Source files
------------

// File: rtl/exc_arbiter.sv
// rtl/exc_arbiter.sv - prioritised exception/interrupt request front end
//
// Purpose: synchronises NCH masked active-low interrupt lines, turns data and
// instruction abort levels into sticky one-shot events, picks the highest
// priority candidate and raises a held request towards decode. A
// request/acknowledge handshake with the pipeline is followed by an optional
// hold-off window.
//
// Ports:
//   nGCLK        core clock, rising edge
//   RESET        asynchronous active-high reset
//   nWAIT        low freezes every register
//   ISYNC        1 = inputs already synchronous (single-flop latency)
//   nINT         active-low interrupt lines
//   int_disable  per-channel mask, 1 = masked
//   DABORT       data abort level (rising edge counts)
//   IABORT       instruction abort level (rising edge counts)
//   exc_ack      pipeline has taken the current request
//   exc_req      exception request, held until acknowledged
//   exc_code     0 = dabort, 1 = iabort, 2+i = interrupt channel i
//   s_nINT       synchronised masked interrupt levels (active low)
//   busy         high while a request is pending or in hold-off

module exc_arbiter #(
  parameter int NCH        = 2,
  parameter int SYNC_DEPTH = 2,
  parameter int HOLDOFF    = 3,
  parameter int CW         = 3
) (
  input  logic           nGCLK,
  input  logic           RESET,
  input  logic           nWAIT,
  input  logic           ISYNC,
  input  logic [NCH-1:0] nINT,
  input  logic [NCH-1:0] int_disable,
  input  logic           DABORT,
  input  logic           IABORT,
  input  logic           exc_ack,
  output logic           exc_req,
  output logic [CW-1:0]  exc_code,
  output logic [NCH-1:0] s_nINT,
  output logic           busy
);

  localparam int CNTW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CNTW-1:0] r_cnt;
  logic [CNTW-1:0] w_cnt_nxt;
  logic            r_req;
  logic            w_req_nxt;
  logic [CW-1:0]   r_code;
  logic [CW-1:0]   w_code_nxt;

  logic [NCH-1:0]  r_sync [SYNC_DEPTH];
  logic [NCH-1:0]  w_sync_in;

  logic            r_dab_prev;
  logic            r_iab_prev;
  logic            r_dab_pend;
  logic            r_iab_pend;
  logic            w_dab_rise;
  logic            w_iab_rise;
  logic            w_ack_take;
  logic            w_dab_clr;
  logic            w_iab_clr;

  logic            w_cand;
  logic [CW-1:0]   w_win;

  // Masking happens ahead of the chain so a masked line never looks asserted.
  assign w_sync_in = nINT | int_disable;

  // The chain always shifts; ISYNC only chooses which stage is observed.
  always_ff @(posedge nGCLK or posedge RESET) begin
    if (RESET) begin
      for (int k = 0; k < SYNC_DEPTH; k++) begin
        r_sync[k] <= '1;
      end
    end else if (nWAIT) begin
      r_sync[0] <= w_sync_in;
      for (int k = 1; k < SYNC_DEPTH; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  assign s_nINT = ISYNC ? r_sync[0] : r_sync[SYNC_DEPTH-1];

  // Abort one-shots: only a 0->1 change relative to the previous sample counts.
  assign w_dab_rise = DABORT & ~r_dab_prev;
  assign w_iab_rise = IABORT & ~r_iab_prev;
  assign w_ack_take = exc_ack & (r_state == ST_PEND);
  assign w_dab_clr  = w_ack_take & (r_code == CW'(0));
  assign w_iab_clr  = w_ack_take & (r_code == CW'(1));

  // A new edge on the same cycle as the clearing ack re-arms the flag.
  always_ff @(posedge nGCLK or posedge RESET) begin
    if (RESET) begin
      r_dab_prev <= 1'b0;
      r_iab_prev <= 1'b0;
      r_dab_pend <= 1'b0;
      r_iab_pend <= 1'b0;
    end else if (nWAIT) begin
      r_dab_prev <= DABORT;
      r_iab_prev <= IABORT;
      r_dab_pend <= (r_dab_pend & ~w_dab_clr) | w_dab_rise;
      r_iab_pend <= (r_iab_pend & ~w_iab_clr) | w_iab_rise;
    end
  end

  // Winner selection: scanning channels downwards lets the lowest index win,
  // then the abort flags override in their own order.
  always_comb begin
    w_cand = 1'b0;
    w_win  = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (!s_nINT[i]) begin
        w_cand = 1'b1;
        w_win  = CW'(i + 2);
      end
    end
    if (r_iab_pend) begin
      w_cand = 1'b1;
      w_win  = CW'(1);
    end
    if (r_dab_pend) begin
      w_cand = 1'b1;
      w_win  = CW'(0);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_req_nxt   = r_req;
    w_code_nxt  = r_code;
    case (r_state)
      ST_IDLE: begin
        if (w_cand) begin
          w_state_nxt = ST_PEND;
          w_req_nxt   = 1'b1;
          w_code_nxt  = w_win;
        end
      end
      ST_PEND: begin
        // Code is frozen here; later higher-priority events wait their turn.
        if (exc_ack) begin
          w_req_nxt = 1'b0;
          if (HOLDOFF > 0) begin
            w_state_nxt = ST_HOLD;
            w_cnt_nxt   = CNTW'(HOLDOFF);
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (r_cnt <= CNTW'(1)) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_req_nxt   = 1'b0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge nGCLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_code  <= '0;
    end else if (nWAIT) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_req   <= w_req_nxt;
      r_code  <= w_code_nxt;
    end
  end

  assign exc_req  = r_req;
  assign exc_code = r_code;
  assign busy     = (r_state != ST_IDLE);

endmodule
